// File: rtl/weight_buffer.sv
// Ping-pong weight store: the host fills the shadow bank while the array reads
// NUM_OUT-wide groups from the active bank over a valid/ready handshake.
module weight_buffer #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int NUM_OUT = 4,
    parameter int ADDR_W  = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      swap,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      req_ready,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [NUM_OUT*DATA_W-1:0] w_data,
    output logic                      active_bank,
    output logic                      swap_pending,
    output logic                      addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]                state;
    logic [DATA_W-1:0]         mem [2][DEPTH];
    logic [NUM_OUT*DATA_W-1:0] fetch;
    logic                      wr_ok;
    logic                      wr_bad;
    logic                      rd_accept;
    logic                      rd_ok;
    logic                      rd_bad;
    logic                      swap_apply;

    assign wr_ok      = wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
    assign wr_bad     = wr_en && !({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_accept  = rd_req && req_ready;
    assign rd_ok      = rd_accept && ({1'b0, rd_addr} < DEPTH_EXT);
    assign rd_bad     = rd_accept && !({1'b0, rd_addr} < DEPTH_EXT);
    assign swap_apply = (state == IDLE) && swap_pending;

    assign req_ready = (state == IDLE) && !swap_pending;
    assign w_valid   = (state == HOLD);

    // Lane addresses wrap at DEPTH; rd_addr is only used when already < DEPTH.
    always_comb begin
        logic [ADDR_W:0] sum;
        fetch = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            sum = {1'b0, rd_addr} + (ADDR_W+1)'(k);
            if (sum >= DEPTH_EXT) begin
                sum = sum - DEPTH_EXT;
            end
            fetch[k*DATA_W +: DATA_W] = mem[active_bank][IDX_W'(sum)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (wr_ok) begin
            // Shadow bank is chosen from the pre-swap active_bank.
            mem[~active_bank][IDX_W'(wr_addr)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            w_data       <= '0;
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            addr_err <= wr_bad || rd_bad;

            if (swap_apply) begin
                active_bank  <= ~active_bank;
                swap_pending <= 1'b0;
            end else if (swap) begin
                swap_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rd_ok) begin
                        state  <= HOLD;
                        w_data <= fetch;
                    end
                end
                HOLD: begin
                    if (w_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_buffer.sv
// Directed bench for weight_buffer: bank fill, reads, backpressure, wrap,
// address errors, swap timing and reset in HOLD.
module tb_weight_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        swap;
    logic        rd_req;
    logic [12:0] rd_addr;
    logic        req_ready;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        active_bank;
    logic        swap_pending;
    logic        addr_err;

    int passed = 0;
    int total  = 0;

    weight_buffer #(.DATA_W(8), .DEPTH(32), .NUM_OUT(4), .ADDR_W(13)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap         (swap),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .req_ready    (req_ready),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .active_bank  (active_bank),
        .swap_pending (swap_pending),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        swap = 1'b0; rd_req = 1'b0; rd_addr = '0; w_ready = 1'b0;
        step(); step();
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_active", 32'(active_bank), 32'd0);
        chk("rst_pending", 32'(swap_pending), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;

        // fill shadow bank 1 with addr+1
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 13'(i); wr_data = 8'(i + 1);
            step();
        end
        wr_en = 1'b0;
        swap = 1'b1; step(); swap = 1'b0;
        chk("swap_pending_set", 32'(swap_pending), 32'd1);
        chk("req_ready_pending", 32'(req_ready), 32'd0);
        step();
        chk("swap_applied", 32'(active_bank), 32'd1);
        step();
        chk("active_after_2", 32'(active_bank), 32'd1);

        // read addr 4 with immediate consumer
        w_ready = 1'b1; rd_req = 1'b1; rd_addr = 13'd4;
        step(); rd_req = 1'b0;
        chk("rd4_valid", 32'(w_valid), 32'd1);
        chk("rd4_data", w_data, 32'h08070605);
        chk("rd4_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("rd4_valid_drop", 32'(w_valid), 32'd0);
        chk("rd4_req_ready_back", 32'(req_ready), 32'd1);
        chk("rd4_data_kept", w_data, 32'h08070605);

        // backpressure
        w_ready = 1'b0; rd_req = 1'b1; rd_addr = 13'd0;
        step(); rd_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(w_valid), 32'd1);
            chk("bp_data", w_data, 32'h04030201);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        w_ready = 1'b1; step();
        chk("bp_valid_drop", 32'(w_valid), 32'd0);
        chk("bp_req_ready_back", 32'(req_ready), 32'd1);

        // wrap
        rd_req = 1'b1; rd_addr = 13'd30;
        step(); rd_req = 1'b0;
        chk("wrap_data", w_data, 32'h0201201F);
        step();

        // out-of-range read
        rd_req = 1'b1; rd_addr = 13'd32;
        step(); rd_req = 1'b0;
        chk("rd_err_pulse", 32'(addr_err), 32'd1);
        chk("rd_err_no_valid", 32'(w_valid), 32'd0);
        chk("rd_err_data_kept", w_data, 32'h0201201F);
        step();
        chk("rd_err_one_cycle", 32'(addr_err), 32'd0);

        // out-of-range write
        wr_en = 1'b1; wr_addr = 13'd40; wr_data = 8'h55;
        step(); wr_en = 1'b0;
        chk("wr_err_pulse", 32'(addr_err), 32'd1);
        step();
        chk("wr_err_one_cycle", 32'(addr_err), 32'd0);

        // swap during HOLD
        w_ready = 1'b0; rd_req = 1'b1; rd_addr = 13'd0;
        step(); rd_req = 1'b0;
        chk("hold_data", w_data, 32'h04030201);
        swap = 1'b1; step(); swap = 1'b0;
        chk("hold_pending", 32'(swap_pending), 32'd1);
        chk("hold_data_stable", w_data, 32'h04030201);
        chk("hold_active_same", 32'(active_bank), 32'd1);
        chk("hold_valid", 32'(w_valid), 32'd1);
        w_ready = 1'b1; step();
        chk("post_hs_valid", 32'(w_valid), 32'd0);
        chk("post_hs_active", 32'(active_bank), 32'd1);
        chk("post_hs_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("hold_swap_applied", 32'(active_bank), 32'd0);
        chk("hold_swap_cleared", 32'(swap_pending), 32'd0);
        rd_req = 1'b1; rd_addr = 13'd0;
        step(); rd_req = 1'b0;
        chk("old_shadow_zero", w_data, 32'd0);
        step();

        // write + swap in same cycle (active_bank=0, so write goes to bank 1)
        wr_en = 1'b1; wr_addr = 13'd3; wr_data = 8'hAA; swap = 1'b1;
        step(); wr_en = 1'b0; swap = 1'b0;
        step();
        chk("ws_active", 32'(active_bank), 32'd1);
        rd_req = 1'b1; rd_addr = 13'd3;
        step(); rd_req = 1'b0;
        chk("ws_data", w_data, 32'h070605AA);
        step();

        // reset while in HOLD
        w_ready = 1'b0; rd_req = 1'b1; rd_addr = 13'd0;
        step(); rd_req = 1'b0;
        chk("pre_rst_valid", 32'(w_valid), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("hold_rst_valid", 32'(w_valid), 32'd0);
        chk("hold_rst_data", w_data, 32'd0);
        chk("hold_rst_active", 32'(active_bank), 32'd0);
        w_ready = 1'b1; rd_req = 1'b1; rd_addr = 13'd30;
        step(); rd_req = 1'b0;
        chk("rst_bank0_zero", w_data, 32'd0);
        step();
        swap = 1'b1; step(); swap = 1'b0; step();
        rd_req = 1'b1; rd_addr = 13'd3;
        step(); rd_req = 1'b0;
        chk("rst_bank1_active", 32'(active_bank), 32'd1);
        chk("rst_bank1_zero", w_data, 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
